// File: rtl/aes_rf_out_arbiter.sv
// aes_rf_out_arbiter
//   Packet-locked 2:1 AXI-stream arbiter. It merges the cipher/pass-through
//   path (source 0) and the invcipher path (source 1) into the single stream
//   that feeds the UART transmitter. A grant is held from the first beat
//   through the tlast beat, so the two paths never interleave. The output is
//   fully registered behind a 2-entry skid buffer.
//
// Ports
//   clk, rst        : clock and synchronous active-high reset
//   s0_axis_*       : source 0 stream (tdata/tvalid/tready/tlast)
//   s1_axis_*       : source 1 stream
//   m_axis_*        : merged output stream
//   clr_cnt         : synchronous clear of both packet counters
//   gnt             : one-hot grant, 2'b00 when idle
//   busy            : a packet is locked
//   pkt_cnt0/1      : completed packets per source (wrapping)
module aes_rf_out_arbiter #(
   parameter bit RR_EN  = 1'b1,
   parameter int CNT_W  = 16,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s0_axis_tdata,
   input  logic              s0_axis_tvalid,
   output logic              s0_axis_tready,
   input  logic              s0_axis_tlast,
   input  logic [DATA_W-1:0] s1_axis_tdata,
   input  logic              s1_axis_tvalid,
   output logic              s1_axis_tready,
   input  logic              s1_axis_tlast,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   input  logic              clr_cnt,
   output logic [1:0]        gnt,
   output logic              busy,
   output logic [CNT_W-1:0]  pkt_cnt0,
   output logic [CNT_W-1:0]  pkt_cnt1
);

   typedef enum logic {IDLE, PASS} state_t;

   state_t                    state;
   logic [1:0]                gnt_q;
   logic                      busy_q;
   logic                      last_gnt;   // 1 = source 1 was served last
   logic                      win;
   logic [1:0]                s_tvalid;
   logic [1:0]                s_tlast;
   logic [1:0][DATA_W-1:0]    s_tdata;
   logic [1:0][CNT_W-1:0]     cnt;

   logic                      in_rdy, in_vld, in_last, acc, pkt_end;
   logic [DATA_W-1:0]         in_data;

   logic                      m_vld, m_last, skid_vld, skid_last;
   logic [DATA_W-1:0]         m_data, skid_data;

   assign s_tvalid = {s1_axis_tvalid, s0_axis_tvalid};
   assign s_tlast  = {s1_axis_tlast,  s0_axis_tlast};
   assign s_tdata  = {s1_axis_tdata,  s0_axis_tdata};

   // Upstream ready depends only on registered state: a free skid slot
   // guarantees room for one more beat whatever m_axis_tready does.
   assign in_rdy  = busy_q && !skid_vld;
   assign in_vld  = |(s_tvalid & gnt_q);
   assign in_data = gnt_q[1] ? s_tdata[1] : s_tdata[0];
   assign in_last = gnt_q[1] ? s_tlast[1] : s_tlast[0];
   assign acc     = in_vld && in_rdy;
   assign pkt_end = acc && in_last;

   assign s0_axis_tready = in_rdy && gnt_q[0];
   assign s1_axis_tready = in_rdy && gnt_q[1];

   // Tie resolution: round-robin prefers the source not served last.
   always_comb begin
      win = 1'b0;
      case (s_tvalid)
         2'b10:   win = 1'b1;
         2'b11:   win = RR_EN ? ~last_gnt : 1'b0;
         default: win = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt_q    <= 2'b00;
         busy_q   <= 1'b0;
         last_gnt <= 1'b1;
      end else begin
         case (state)
            IDLE: if (|s_tvalid) begin
               state  <= PASS;
               gnt_q  <= win ? 2'b10 : 2'b01;
               busy_q <= 1'b1;
            end
            PASS: if (pkt_end) begin
               state    <= IDLE;
               gnt_q    <= 2'b00;
               busy_q   <= 1'b0;
               last_gnt <= gnt_q[1];
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Per-source packet counters; clear beats a coincident increment.
   for (genvar i = 0; i < 2; i++) begin : g_cnt
      always_ff @(posedge clk) begin
         if (rst || clr_cnt)
            cnt[i] <= '0;
         else if (pkt_end && gnt_q[i])
            cnt[i] <= cnt[i] + CNT_W'(1);
      end
   end

   // Skid buffer: the output register refills from the skid slot first, then
   // from the input. A beat arriving while the output is stalled parks in
   // the skid slot, which drops upstream ready for the next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_vld     <= 1'b0;
         m_data    <= '0;
         m_last    <= 1'b0;
         skid_vld  <= 1'b0;
         skid_data <= '0;
         skid_last <= 1'b0;
      end else if (m_axis_tready || !m_vld) begin
         if (skid_vld) begin
            m_vld    <= 1'b1;
            m_data   <= skid_data;
            m_last   <= skid_last;
            skid_vld <= 1'b0;
         end else begin
            m_vld <= acc;
            if (acc) begin
               m_data <= in_data;
               m_last <= in_last;
            end
         end
      end else if (acc) begin
         skid_vld  <= 1'b1;
         skid_data <= in_data;
         skid_last <= in_last;
      end
   end

   assign m_axis_tvalid = m_vld;
   assign m_axis_tdata  = m_data;
   assign m_axis_tlast  = m_last;
   assign gnt           = gnt_q;
   assign busy          = busy_q;
   assign pkt_cnt0      = cnt[0];
   assign pkt_cnt1      = cnt[1];

endmodule
